// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a req/ack instruction memory,
// buffers an instruction across stalls and applies ID redirects with one delay slot.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        fetch_wait
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] hold_inst;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] tgt;
  logic            redir_vld;
  logic            deliver;
  logic            advance;
  logic            redir_take;

  // Redirect target selected by ID
  always_comb begin
    tgt = rpc;
    case (pcsrc)
      2'b01:   tgt = bpc;
      2'b10:   tgt = jpc;
      default: tgt = rpc;
    endcase
  end

  // Request and delivery; reset suppresses both and ignores any ack
  always_comb begin
    imem_req = 1'b0;
    deliver  = 1'b0;
    if_inst  = NOP;
    if (!clr) begin
      if (state == HOLD) begin
        deliver = 1'b1;
        if_inst = hold_inst;
      end else begin
        imem_req = 1'b1;
        deliver  = imem_ack;
        if (imem_ack) begin
          if_inst = imem_rdata;
        end
      end
    end
  end

  assign pc_plus4   = pc + XLEN'(4);
  assign advance    = deliver && !stall;
  // Branch left ID during a bubble: its delay slot is still in flight, remember the target
  assign redir_take = !deliver && !stall && (pcsrc != 2'b00) && !redir_vld;
  assign imem_addr  = pc;
  assign if_pc4     = pc_plus4;
  assign fetch_wait = (state == FETCH) && !imem_ack;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      hold_inst <= '0;
      redir_vld <= 1'b0;
      redir_pc  <= '0;
    end else begin
      if (advance) begin
        if (redir_vld) begin
          pc        <= redir_pc;
          redir_vld <= 1'b0;
        end else if (pcsrc != 2'b00) begin
          pc <= tgt;
        end else begin
          pc <= pc_plus4;
        end
      end else if (redir_take) begin
        redir_vld <= 1'b1;
        redir_pc  <= tgt;
      end

      case (state)
        FETCH: begin
          if (imem_ack && stall) begin
            hold_inst <= imem_rdata;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            state <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency memory model and a
// per-cycle expectation queue.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP_W = 32'h0000_0000;
  localparam logic [31:0] IDLE_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        clr;
  logic        stall;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, jpc, rpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        fetch_wait;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int wcnt  = 0;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        dlv;
    logic        wt;
  } exp_t;

  exp_t sb[$];

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP(NOP_W)) dut (
    .clk        (clk),
    .clr        (clr),
    .stall      (stall),
    .pcsrc      (pcsrc),
    .bpc        (bpc),
    .jpc        (jpc),
    .rpc        (rpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_pc4     (if_pc4),
    .if_inst    (if_inst),
    .fetch_wait (fetch_wait)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory: acks after lat cycles of a held request; data only visible while requested
  always @(posedge clk) begin
    if (clr || !imem_req || imem_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end
  assign imem_ack   = imem_req && (wcnt >= lat - 1);
  assign imem_rdata = imem_req ? mem_word(imem_addr) : IDLE_DATA;

  task automatic check_out();
    exp_t        e;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc4;
    e        = sb.pop_front();
    exp_inst = e.dlv ? mem_word(e.addr) : NOP_W;
    exp_pc4  = e.addr + 32'd4;
    total++;
    assert (imem_req === e.req) else begin
      bad++; $error("FAIL req obs=%0b exp=%0b @%0t", imem_req, e.req, $time);
    end
    total++;
    assert (imem_addr === e.addr) else begin
      bad++; $error("FAIL addr obs=%h exp=%h @%0t", imem_addr, e.addr, $time);
    end
    total++;
    assert (if_inst === exp_inst) else begin
      bad++; $error("FAIL inst obs=%h exp=%h @%0t", if_inst, exp_inst, $time);
    end
    total++;
    assert (if_pc4 === exp_pc4) else begin
      bad++; $error("FAIL pc4 obs=%h exp=%h @%0t", if_pc4, exp_pc4, $time);
    end
    total++;
    assert (fetch_wait === e.wt) else begin
      bad++; $error("FAIL wait obs=%0b exp=%0b @%0t", fetch_wait, e.wt, $time);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check at the falling edge
  task automatic step(input logic cl, input logic st, input logic [1:0] ps,
                      input logic [31:0] tg, input logic r, input logic [31:0] a,
                      input logic d, input logic w);
    exp_t e;
    clr = cl; stall = st; pcsrc = ps;
    bpc = tg; jpc = tg; rpc = tg;
    e.req = r; e.addr = a; e.dlv = d; e.wt = w;
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_redir(input logic exp_v);
    total++;
    assert (dut.redir_vld === exp_v) else begin
      bad++; $error("FAIL redir_vld obs=%0b exp=%0b @%0t", dut.redir_vld, exp_v, $time);
    end
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; pcsrc = 2'b00;
    bpc = '0; jpc = '0; rpc = '0;
    @(posedge clk);
    #1;
    // reset held: no request, NOP, PC at reset value
    step(1, 0, 2'b00, 32'h0, 0, 32'h0, 0, 1);

    // zero-wait sequential fetch, then branch with delay slot at 0x10
    step(0, 0, 2'b00, 32'h0,  1, 32'h00, 1, 0);
    step(0, 0, 2'b00, 32'h0,  1, 32'h04, 1, 0);
    step(0, 0, 2'b00, 32'h0,  1, 32'h08, 1, 0);
    step(0, 0, 2'b00, 32'h0,  1, 32'h0C, 1, 0);
    step(0, 0, 2'b01, 32'h40, 1, 32'h10, 1, 0);
    step(0, 0, 2'b00, 32'h0,  1, 32'h40, 1, 0);
    step(0, 0, 2'b00, 32'h0,  1, 32'h44, 1, 0);

    // two-cycle latency: bubble/word alternation
    lat = 2;
    step(0, 0, 2'b00, 32'h0, 1, 32'h48, 0, 1);
    step(0, 0, 2'b00, 32'h0, 1, 32'h48, 1, 0);
    step(0, 0, 2'b00, 32'h0, 1, 32'h4C, 0, 1);
    step(0, 0, 2'b00, 32'h0, 1, 32'h4C, 1, 0);
    step(0, 0, 2'b00, 32'h0, 1, 32'h50, 0, 1);
    step(0, 0, 2'b00, 32'h0, 1, 32'h50, 1, 0);

    // ack under stall -> HOLD for the stall, no bubble on release
    lat = 1;
    step(0, 1, 2'b00, 32'h0, 1, 32'h54, 1, 0);
    step(0, 1, 2'b00, 32'h0, 0, 32'h54, 1, 0);
    step(0, 1, 2'b00, 32'h0, 0, 32'h54, 1, 0);
    step(0, 0, 2'b00, 32'h0, 0, 32'h54, 1, 0);
    step(0, 0, 2'b00, 32'h0, 1, 32'h58, 1, 0);

    // three-cycle latency: jump latched in a bubble, delay slot first
    lat = 3;
    step(0, 0, 2'b10, 32'h100, 1, 32'h5C, 0, 1);
    chk_redir(1'b1);
    step(0, 0, 2'b00, 32'h0,   1, 32'h5C, 0, 1);
    step(0, 0, 2'b00, 32'h0,   1, 32'h5C, 1, 0);
    chk_redir(1'b0);
    step(0, 0, 2'b11, 32'h200, 1, 32'h100, 0, 1);
    chk_redir(1'b1);
    step(0, 0, 2'b00, 32'h0,   1, 32'h100, 0, 1);
    step(0, 1, 2'b00, 32'h0,   1, 32'h100, 1, 0);
    step(0, 1, 2'b00, 32'h0,   0, 32'h100, 1, 0);
    chk_redir(1'b1);

    // reset while in HOLD with a pending redirect
    step(1, 1, 2'b00, 32'h0, 0, 32'h100, 0, 0);
    chk_redir(1'b0);
    step(0, 0, 2'b00, 32'h0,  1, 32'h0, 0, 1);
    // pcsrc under stall must be ignored
    step(0, 1, 2'b01, 32'h80, 1, 32'h0, 0, 1);
    chk_redir(1'b0);
    step(0, 0, 2'b00, 32'h0,  1, 32'h0, 1, 0);

    // jr to the top word: if_pc4 wraps to zero
    step(0, 0, 2'b11, 32'hFFFF_FFFC, 1, 32'h4, 0, 1);
    step(0, 0, 2'b00, 32'h0,         1, 32'h4, 0, 1);
    step(0, 0, 2'b00, 32'h0,         1, 32'h4, 1, 0);
    step(0, 0, 2'b00, 32'h0,         1, 32'hFFFF_FFFC, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
